// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver with majority vote, break detect and status FIFO
// Ports: clk/reset (sync, active-high); rx_en_i gates start detection; tick_i is the
// OVERSAMPLE x baud strobe; rx_i is the async serial line; data_bit_num_i/parity_en_i/
// parity_type_i/stop_bit_num_i set the frame format (latched at start); data_o/flags show
// the FIFO head, popped by data_valid_o & data_ready_i; overrun_o pulses on a dropped frame;
// fifo_level_o is the entry count; rts_no requests the sender to stop; busy_o = not idle.
module uart_rx_oversampled #(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 9,
    parameter int FIFO_DEPTH    = 8,
    parameter int RTS_LEVEL     = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_en_i,
    input  logic                          tick_i,
    input  logic                          rx_i,
    input  logic [2:0]                    data_bit_num_i,
    input  logic                          parity_en_i,
    input  logic                          parity_type_i,
    input  logic                          stop_bit_num_i,
    output logic [MAX_DATA_BITS-1:0]      data_o,
    output logic                          data_valid_o,
    input  logic                          data_ready_i,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          break_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          rts_no,
    output logic                          busy_o
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = MAX_DATA_BITS + 3;
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3,
                           S_STOP = 3'd4, S_DONE = 3'd5, S_BRK = 3'd6;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, rx_s;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             smp_q, smp_d;
    logic [3:0]             bidx_q, bidx_d, nbits_q, nbits_d, dbn_w, nbits_in;
    logic                   pen_q, pen_d, ptype_q, ptype_d, two_q, two_d, second_q, second_d;
    logic                   par_q, par_d, zero_q, zero_d, ferr_q, ferr_d, perr_q, perr_d, brk_q, brk_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                   tick_end, vote_tick, v;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]          wptr_q, rptr_q;
    logic [LW-1:0]          count_q, count_d;
    logic                   rts_q, ovr_q, push, pop, full, push_ok;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign tick_end  = tick_i && cnt_q == CW'(OVERSAMPLE - 1);
    assign vote_tick = tick_i && cnt_q == CW'(M + 1);
    // the third sample is the live synchronised line on the vote tick
    assign v         = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign dbn_w     = 4'(data_bit_num_i) + 4'd5;
    assign nbits_in  = (dbn_w > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) : dbn_w;

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick_i ? (tick_end ? '0 : cnt_q + CW'(1)) : cnt_q;
        smp_d    = smp_q;
        bidx_d   = bidx_q;
        nbits_d  = nbits_q;
        pen_d    = pen_q;
        ptype_d  = ptype_q;
        two_d    = two_q;
        second_d = second_q;
        par_d    = par_q;
        zero_d   = zero_q;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        brk_d    = brk_q;
        data_d   = data_q;
        if (tick_i && cnt_q == CW'(M - 1)) smp_d[0] = rx_s;
        if (tick_i && cnt_q == CW'(M)) smp_d[1] = rx_s;
        case (state_q)
            S_IDLE: if (rx_en_i && prev_q && !rx_s) begin
                state_d  = S_START;
                cnt_d    = '0;
                nbits_d  = nbits_in;
                pen_d    = parity_en_i;
                ptype_d  = parity_type_i;
                two_d    = stop_bit_num_i;
                second_d = 1'b0;
                bidx_d   = '0;
                data_d   = '0;
                par_d    = 1'b0;
                zero_d   = 1'b1;
                ferr_d   = 1'b0;
                perr_d   = 1'b0;
                brk_d    = 1'b0;
            end
            S_START: state_d = (vote_tick && v) ? S_IDLE : (tick_end ? S_DATA : S_START);
            S_DATA: begin
                if (vote_tick) begin
                    data_d[bidx_q] = v;
                    par_d          = par_q ^ v;
                    zero_d         = zero_q & ~v;
                end
                if (tick_end) begin
                    bidx_d = bidx_q + 4'd1;
                    if (bidx_q == nbits_q - 4'd1) state_d = pen_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (vote_tick) begin
                    perr_d = (par_q ^ v) != ptype_q;
                    zero_d = zero_q & ~v;
                end
                if (tick_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (vote_tick) begin
                    // an all-zero character with a low first stop bit is a break
                    if (!second_q && zero_q && !v) begin
                        brk_d   = 1'b1;
                        ferr_d  = 1'b1;
                        perr_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        ferr_d = ferr_q | ~v;
                        if (second_q || !two_q) state_d = S_DONE;
                    end
                end else if (tick_end) second_d = 1'b1;
            end
            S_DONE:  state_d = brk_q ? S_BRK : S_IDLE;
            S_BRK:   state_d = rx_s ? S_IDLE : S_BRK;
            default: state_d = S_IDLE;
        endcase
    end

    assign push    = state_q == S_DONE;
    assign data_valid_o = count_q != '0;
    assign pop     = data_valid_o & data_ready_i;
    assign full    = count_q == LW'(FIFO_DEPTH);
    assign push_ok = push & (~full | pop);
    assign count_d = count_q + LW'(push_ok) - LW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '1;
            prev_q   <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            smp_q    <= '0;
            bidx_q   <= '0;
            nbits_q  <= '0;
            pen_q    <= 1'b0;
            ptype_q  <= 1'b0;
            two_q    <= 1'b0;
            second_q <= 1'b0;
            par_q    <= 1'b0;
            zero_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            brk_q    <= 1'b0;
            data_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rts_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q   <= rx_s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            smp_q    <= smp_d;
            bidx_q   <= bidx_d;
            nbits_q  <= nbits_d;
            pen_q    <= pen_d;
            ptype_q  <= ptype_d;
            two_q    <= two_d;
            second_q <= second_d;
            par_q    <= par_d;
            zero_q   <= zero_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            brk_q    <= brk_d;
            data_q   <= data_d;
            wptr_q   <= push_ok ? wptr_q + AW'(1) : wptr_q;
            rptr_q   <= pop ? rptr_q + AW'(1) : rptr_q;
            count_q  <= count_d;
            rts_q    <= count_d >= LW'(RTS_LEVEL);
            ovr_q    <= push & ~push_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= {brk_q, ferr_q, perr_q, data_q};
    end

    assign {break_o, frame_err_o, parity_err_o, data_o} = data_valid_o ? mem[rptr_q] : '0;
    assign fifo_level_o = count_q;
    assign rts_no       = rts_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = state_q != S_IDLE;
endmodule
